addroundkey_keysched: RTL and testbench

- AddRoundKey stage with an on-the-fly AES-128 key schedule.
- Sits directly downstream of mixcolumn and consumes its 128-bit state output.
- XORs each accepted state with the current round key, registers the result, then advances the key schedule to the next round key.
- Cycles through round keys 0..10 and wraps to 0, so a full encryption is 11 accepted states.

---
 rtl/addroundkey_keysched.sv | 155 +++++++++++++++
 tb/tb_addroundkey_keysched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addroundkey_keysched.sv
// AddRoundKey stage with an on-the-fly AES-128 key schedule.
// Each accepted state is XORed with the current round key and registered.
// The key register then steps to the next round key. After round NR it wraps
// back to the stored cipher key.
module addroundkey_keysched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [0:127] cipher_key,
    input  logic         state_valid,
    input  logic [0:127] state_in,
    output logic         key_ready,
    output logic         out_valid,
    output logic [0:127] state_out,
    output logic [3:0]   round_out,
    output logic         last_round,
    output logic         drop_err
);

    localparam logic [3:0] LAST_RC = 4'(NR);

    // FIPS-197 forward S-box, indexed by the input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Words are held as [31:0] with bits [31:24] being the word's first byte.
    function automatic logic [0:127] next_key(input logic [0:127] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[0:31];
        w1 = k[32:63];
        w2 = k[64:95];
        w3 = k[96:127];
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (8'h1b & {8{r[7]}});
    endfunction

    logic [0:127] ks_q, ks_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   rc_q, rc_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         key_ready_q, key_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [0:127] state_out_q, state_out_d;
    logic [3:0]   round_out_q, round_out_d;
    logic         last_round_q, last_round_d;
    logic         drop_err_q, drop_err_d;
    logic [0:127] rk_next;

    // Next round key, one full schedule step from the current key.
    always_comb begin
        rk_next = next_key(rk_q, rcon_q);
    end

    // Key load has priority; otherwise accept or drop the incoming state.
    always_comb begin
        ks_d         = ks_q;
        rk_d         = rk_q;
        rc_d         = rc_q;
        rcon_d       = rcon_q;
        key_ready_d  = key_ready_q;
        out_valid_d  = 1'b0;
        state_out_d  = state_out_q;
        round_out_d  = round_out_q;
        last_round_d = 1'b0;
        drop_err_d   = drop_err_q;

        if (key_load) begin
            ks_d        = cipher_key;
            rk_d        = cipher_key;
            rc_d        = 4'd0;
            rcon_d      = 8'h01;
            key_ready_d = 1'b1;
            if (state_valid) drop_err_d = 1'b1;
        end else if (state_valid) begin
            if (key_ready_q) begin
                state_out_d  = state_in ^ rk_q;
                round_out_d  = rc_q;
                out_valid_d  = 1'b1;
                last_round_d = (rc_q == LAST_RC);
                if (rc_q == LAST_RC) begin
                    rk_d   = ks_q;
                    rc_d   = 4'd0;
                    rcon_d = 8'h01;
                end else begin
                    rk_d   = rk_next;
                    rc_d   = rc_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                end
            end else begin
                drop_err_d = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_q         <= '0;
            rk_q         <= '0;
            rc_q         <= '0;
            rcon_q       <= '0;
            key_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            state_out_q  <= '0;
            round_out_q  <= '0;
            last_round_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            ks_q         <= ks_d;
            rk_q         <= rk_d;
            rc_q         <= rc_d;
            rcon_q       <= rcon_d;
            key_ready_q  <= key_ready_d;
            out_valid_q  <= out_valid_d;
            state_out_q  <= state_out_d;
            round_out_q  <= round_out_d;
            last_round_q <= last_round_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign out_valid  = out_valid_q;
    assign state_out  = state_out_q;
    assign round_out  = round_out_q;
    assign last_round = last_round_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_addroundkey_keysched.sv
// Bench for addroundkey_keysched: known-answer table, corner sequences,
// and random traffic checked against a FIPS-197 key-expansion model.
module tb_addroundkey_keysched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0;
    logic [0:127] cipher_key = '0;
    logic         state_valid = 1'b0;
    logic [0:127] state_in = '0;
    logic         key_ready, out_valid, last_round, drop_err;
    logic [0:127] state_out;
    logic [3:0]   round_out;

    int n_checks = 0;
    int n_err    = 0;

    addroundkey_keysched #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .cipher_key(cipher_key),
        .state_valid(state_valid), .state_in(state_in), .key_ready(key_ready),
        .out_valid(out_valid), .state_out(state_out), .round_out(round_out),
        .last_round(last_round), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [0:127] m_rk [11];
    bit           m_loaded, m_drop, m_valid, m_last;
    int           m_rc, m_round;
    logic [0:127] m_out;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_reset();
        m_loaded = 0; m_drop = 0; m_valid = 0; m_last = 0;
        m_rc = 0; m_round = 0; m_out = '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Step model with current inputs, clock once, compare every output.
    task automatic cycle();
        m_valid = 0;
        m_last  = 0;
        if (key_load) begin
            if (state_valid) m_drop = 1;
            expand(cipher_key);
            m_loaded = 1;
            m_rc = 0;
        end else if (state_valid) begin
            if (m_loaded) begin
                m_valid = 1;
                m_out   = state_in ^ m_rk[m_rc];
                m_round = m_rc;
                m_last  = (m_rc == 10);
                m_rc    = (m_rc + 1) % 11;
            end else begin
                m_drop = 1;
            end
        end
        @(posedge clk); #1;
        chk("out_valid",  128'(out_valid),  128'(m_valid));
        chk("state_out",  state_out,        m_out);
        chk("round_out",  128'(round_out),  128'(m_round));
        chk("last_round", 128'(last_round), 128'(m_last));
        chk("key_ready",  128'(key_ready),  128'(m_loaded));
        chk("drop_err",   128'(drop_err),   128'(m_drop));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_key_ready"},  128'(key_ready),  '0);
        chk({nm, "_out_valid"},  128'(out_valid),  '0);
        chk({nm, "_state_out"},  state_out,        '0);
        chk({nm, "_round_out"},  128'(round_out),  '0);
        chk({nm, "_last_round"}, 128'(last_round), '0);
        chk({nm, "_drop_err"},   128'(drop_err),   '0);
    endtask

    task automatic idle();
        key_load = 0; state_valid = 0; state_in = '0;
    endtask

    // ---------------- known-answer table ----------------
    typedef struct {
        bit           kl;
        bit           sv;
        logic [0:127] st;
        bit           kat;
        logic [0:127] exp;
        int           rnd;
        bit           last;
    } vec_t;

    vec_t tbl [15];
    localparam logic [0:127] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        for (int i = 0; i < 15; i++) tbl[i] = '{0, 0, '0, 0, '0, 0, 0};
        tbl[0] = '{1, 0, '0, 0, '0, 0, 0};
        tbl[1] = '{0, 1, 128'h3243f6a8885a308d313198a2e0370734, 1,
                   128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 0};
        tbl[2] = '{1, 0, '0, 0, '0, 0, 0};
        for (int i = 3; i < 15; i++) tbl[i].sv = 1;
        tbl[3]  = '{0, 1, '0, 1, KEY, 0, 0};
        tbl[4]  = '{0, 1, '0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1, 0};
        tbl[13] = '{0, 1, '0, 1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10, 1};
        tbl[14] = '{0, 1, '0, 1, KEY, 0, 0};

        for (int b = 0; b < 256; b++) begin
            logic [7:0] v;
            v = ginv(8'(b));
            sb[b] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
        end
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 0;

        // tests 1-3: table
        cipher_key = KEY;
        for (int i = 0; i < 15; i++) begin
            key_load = tbl[i].kl; state_valid = tbl[i].sv; state_in = tbl[i].st;
            cycle();
            if (tbl[i].kat) begin
                chk($sformatf("kat%0d_out", i),   state_out,         tbl[i].exp);
                chk($sformatf("kat%0d_valid", i), 128'(out_valid),   128'(1));
                chk($sformatf("kat%0d_round", i), 128'(round_out),   128'(tbl[i].rnd));
                chk($sformatf("kat%0d_last", i),  128'(last_round),  128'(tbl[i].last));
            end
        end
        idle(); cycle();

        // test 4: drops before key and with simultaneous key_load
        rst = 1; #1; rst = 0; model_reset();
        state_valid = 1; state_in = 128'h00112233445566778899aabbccddeeff;
        cycle();
        chk("drop_nokey_valid", 128'(out_valid), '0);
        chk("drop_nokey_err",   128'(drop_err),  128'(1));
        key_load = 1;
        cycle();
        chk("drop_kl_valid", 128'(out_valid), '0);
        chk("drop_kl_ready", 128'(key_ready), 128'(1));
        key_load = 0; state_valid = 1; state_in = '0;
        cycle();
        chk("after_drop_round0", state_out, KEY);

        // test 5: async reset at round 5
        idle(); key_load = 1; cycle();
        key_load = 0; state_valid = 1;
        for (int i = 0; i < 5; i++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        idle();
        #3; rst = 1; #1;
        chk_all_zero("async_rst");
        @(posedge clk); #2; rst = 0; model_reset();
        key_load = 1; cycle();
        key_load = 0; state_valid = 1; state_in = '0; cycle();
        chk("rst_reload_round", 128'(round_out), '0);
        chk("rst_reload_out",   state_out,       KEY);

        // test 6: gapped input
        idle(); key_load = 1; cycle();
        key_load = 0;
        state_valid = 1; state_in = 128'h0f0e0d0c0b0a09080706050403020100; cycle();
        chk("gap_v0", 128'(out_valid), 128'(1));
        chk("gap_r0", 128'(round_out), '0);
        state_valid = 0; cycle();
        chk("gap_v1", 128'(out_valid), '0);
        state_valid = 1; state_in = '0; cycle();
        chk("gap_v2", 128'(out_valid), 128'(1));
        chk("gap_r1", 128'(round_out), 128'(1));

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            key_load    = ($urandom_range(0, 24) == 0);
            if (key_load) cipher_key = {$urandom, $urandom, $urandom, $urandom};
            state_valid = ($urandom_range(0, 3) != 0);
            state_in    = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        idle(); cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
